// File: rtl/address_router_pkg.sv
// Shared types and helpers for the address router and its per-channel engine.
package address_router_pkg;

   // Access size encoding carried on the read_size_* / write_size ports
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } acc_size_e;

   // Per-channel FSM state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } chan_state_e;

   // Debug view of all three channel FSMs
   typedef struct packed {
      chan_state_e w;
      chan_state_e r2;
      chan_state_e r1;
   } dbg_state_t;

   // True when the low address bits do not match the natural alignment of the size
   function automatic logic is_misaligned(input logic [1:0] addr_lo, input acc_size_e size);
      return ((size == SZ_HALF) && addr_lo[0]) ||
             ((size == SZ_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/address_router_chan.sv
// One routing channel: decode, region latch, request hold, timeout and error response.
module address_router_chan
   import address_router_pkg::*;
#(
   parameter int WORD_SIZE   = 32,
   parameter int LOG_SIZE    = 12,
   parameter int NUM_REGIONS = 2,
   parameter int TIMEOUT     = 15,
   parameter bit DATA_EN     = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req,
   input  logic [WORD_SIZE-1:0]             addr,
   input  logic [1:0]                       size,
   output logic [NUM_REGIONS-1:0]           tgt_en,
   input  logic [NUM_REGIONS*WORD_SIZE-1:0] tgt_data,
   input  logic [NUM_REGIONS-1:0]           tgt_valid,
   output logic                             rsp_valid,
   output logic                             rsp_err,
   output logic [WORD_SIZE-1:0]             rsp_data,
   output chan_state_e                      state_dbg
);

   localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   chan_state_e          state;
   logic [RW-1:0]        region_q;
   logic [CW-1:0]        cnt_q;
   logic [WORD_SIZE-1:0] region_full;
   logic [RW-1:0]        region_d;
   logic [RW-1:0]        sel;
   logic [WORD_SIZE-1:0] sel_data;
   logic                 fault;
   logic                 last_wait;

   // Decode the incoming address; faults cover unmapped regions, bad size and misalignment
   assign region_full = addr >> LOG_SIZE;
   assign region_d    = region_full[RW-1:0];
   assign fault       = (region_full >= WORD_SIZE'(NUM_REGIONS)) ||
                        (acc_size_e'(size) == SZ_BAD) ||
                        is_misaligned(addr[1:0], acc_size_e'(size));

   // While BUSY the latched region steers data; in IDLE the fresh decode does
   assign sel       = (state == BUSY) ? region_q : region_d;
   assign sel_data  = tgt_data[int'(sel)*WORD_SIZE +: WORD_SIZE];
   assign last_wait = (cnt_q == CW'(TIMEOUT - 1));
   assign state_dbg = state;

   // Target enables and the response strobe; everything is forced low while reset is held
   always_comb begin
      tgt_en    = '0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
      if (rst_n) begin
         unique case (state)
            IDLE: begin
               if (req && !fault) begin
                  tgt_en[region_d] = 1'b1;
                  if (tgt_valid[region_d]) begin
                     rsp_valid = 1'b1;
                     if (DATA_EN) rsp_data = sel_data;
                  end
               end
            end
            BUSY: begin
               if (req) begin
                  if (tgt_valid[region_q]) begin
                     tgt_en[region_q] = 1'b1;
                     rsp_valid        = 1'b1;
                     if (DATA_EN) rsp_data = sel_data;
                  end else if (last_wait) begin
                     rsp_valid = 1'b1;
                     rsp_err   = 1'b1;
                  end else begin
                     tgt_en[region_q] = 1'b1;
                  end
               end
            end
            ERR: begin
               rsp_valid = 1'b1;
               rsp_err   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Channel FSM with region latch and wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         region_q <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  if (fault) begin
                     state <= ERR;
                  end else begin
                     region_q <= region_d;
                     cnt_q    <= '0;
                     if (!tgt_valid[region_d]) state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (!req || tgt_valid[region_q] || last_wait) state <= IDLE;
               else cnt_q <= cnt_q + 1'b1;
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/address_router.sv
// Memory-map router: two read channels and one write channel onto NUM_REGIONS targets.
// Handshake: a request line is held high until its valid strobe; valid is a one-cycle
// pulse, err qualifies it, and a channel takes a new request only in a later IDLE cycle.
module address_router
   import address_router_pkg::*;
#(
   parameter int WORD_SIZE   = 32,
   parameter int LOG_SIZE    = 12,
   parameter int NUM_REGIONS = 2,
   parameter int TIMEOUT     = 15
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             read_one,
   input  logic                             read_sign_one,
   input  logic [WORD_SIZE-1:0]             read_addr_one,
   input  logic [1:0]                       read_size_one,
   output logic [WORD_SIZE-1:0]             read_data_one,
   output logic                             read_valid_one,
   output logic                             read_err_one,
   input  logic                             read_two,
   input  logic                             read_sign_two,
   input  logic [WORD_SIZE-1:0]             read_addr_two,
   input  logic [1:0]                       read_size_two,
   output logic [WORD_SIZE-1:0]             read_data_two,
   output logic                             read_valid_two,
   output logic                             read_err_two,
   input  logic                             wren,
   input  logic [1:0]                       write_size,
   input  logic [WORD_SIZE-1:0]             write_addr,
   input  logic [WORD_SIZE-1:0]             write_data,
   output logic                             write_valid,
   output logic                             write_err,
   output logic [NUM_REGIONS-1:0]           tgt_read_one,
   output logic [NUM_REGIONS-1:0]           tgt_read_two,
   input  logic [NUM_REGIONS*WORD_SIZE-1:0] tgt_rdata_one,
   input  logic [NUM_REGIONS*WORD_SIZE-1:0] tgt_rdata_two,
   input  logic [NUM_REGIONS-1:0]           tgt_rvalid_one,
   input  logic [NUM_REGIONS-1:0]           tgt_rvalid_two,
   output logic [NUM_REGIONS-1:0]           tgt_wren,
   input  logic [NUM_REGIONS-1:0]           tgt_wvalid,
   output dbg_state_t                       dbg_state
);

   chan_state_e          r1_state;
   chan_state_e          r2_state;
   chan_state_e          w_state;
   logic [WORD_SIZE-1:0] w_rsp_data_unused;
   logic                 unused_inputs;

   address_router_chan #(
      .WORD_SIZE(WORD_SIZE), .LOG_SIZE(LOG_SIZE), .NUM_REGIONS(NUM_REGIONS),
      .TIMEOUT(TIMEOUT), .DATA_EN(1'b1)
   ) u_r1 (
      .clk(clk), .rst_n(rst_n), .req(read_one), .addr(read_addr_one), .size(read_size_one),
      .tgt_en(tgt_read_one), .tgt_data(tgt_rdata_one), .tgt_valid(tgt_rvalid_one),
      .rsp_valid(read_valid_one), .rsp_err(read_err_one), .rsp_data(read_data_one),
      .state_dbg(r1_state)
   );

   address_router_chan #(
      .WORD_SIZE(WORD_SIZE), .LOG_SIZE(LOG_SIZE), .NUM_REGIONS(NUM_REGIONS),
      .TIMEOUT(TIMEOUT), .DATA_EN(1'b1)
   ) u_r2 (
      .clk(clk), .rst_n(rst_n), .req(read_two), .addr(read_addr_two), .size(read_size_two),
      .tgt_en(tgt_read_two), .tgt_data(tgt_rdata_two), .tgt_valid(tgt_rvalid_two),
      .rsp_valid(read_valid_two), .rsp_err(read_err_two), .rsp_data(read_data_two),
      .state_dbg(r2_state)
   );

   // Write channel returns no data, so its data path is tied off
   address_router_chan #(
      .WORD_SIZE(WORD_SIZE), .LOG_SIZE(LOG_SIZE), .NUM_REGIONS(NUM_REGIONS),
      .TIMEOUT(TIMEOUT), .DATA_EN(1'b0)
   ) u_w (
      .clk(clk), .rst_n(rst_n), .req(wren), .addr(write_addr), .size(write_size),
      .tgt_en(tgt_wren), .tgt_data({(NUM_REGIONS*WORD_SIZE){1'b0}}), .tgt_valid(tgt_wvalid),
      .rsp_valid(write_valid), .rsp_err(write_err), .rsp_data(w_rsp_data_unused),
      .state_dbg(w_state)
   );

   // Sign and write data travel to the targets on their own broadcast wiring
   assign unused_inputs = ^{read_sign_one, read_sign_two, write_data, w_rsp_data_unused};

   // Collect channel states for observation
   assign dbg_state = '{w: w_state, r2: r2_state, r1: r1_state};

endmodule

// File: tb/tb_address_router.sv
// Directed bench for address_router with a queue-based response scoreboard.
module tb_address_router;
   import address_router_pkg::*;

   localparam int W = 32;
   localparam int N = 2;

   logic           clk;
   logic           rst_n;
   logic           read_one, read_sign_one, read_two, read_sign_two;
   logic [W-1:0]   read_addr_one, read_addr_two;
   logic [1:0]     read_size_one, read_size_two;
   logic [W-1:0]   read_data_one, read_data_two;
   logic           read_valid_one, read_err_one, read_valid_two, read_err_two;
   logic           wren;
   logic [1:0]     write_size;
   logic [W-1:0]   write_addr, write_data;
   logic           write_valid, write_err;
   logic [N-1:0]   tgt_read_one, tgt_read_two, tgt_wren;
   logic [N*W-1:0] tgt_rdata_one, tgt_rdata_two;
   logic [N-1:0]   tgt_rvalid_one, tgt_rvalid_two, tgt_wvalid;
   dbg_state_t     dbg_state;

   logic [W:0] exp_q1[$];
   logic [W:0] exp_q2[$];
   logic [W:0] exp_qw[$];

   int checks = 0;
   int errors = 0;

   address_router #(.WORD_SIZE(W), .LOG_SIZE(12), .NUM_REGIONS(N), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .read_one(read_one), .read_sign_one(read_sign_one), .read_addr_one(read_addr_one),
      .read_size_one(read_size_one), .read_data_one(read_data_one),
      .read_valid_one(read_valid_one), .read_err_one(read_err_one),
      .read_two(read_two), .read_sign_two(read_sign_two), .read_addr_two(read_addr_two),
      .read_size_two(read_size_two), .read_data_two(read_data_two),
      .read_valid_two(read_valid_two), .read_err_two(read_err_two),
      .wren(wren), .write_size(write_size), .write_addr(write_addr), .write_data(write_data),
      .write_valid(write_valid), .write_err(write_err),
      .tgt_read_one(tgt_read_one), .tgt_read_two(tgt_read_two),
      .tgt_rdata_one(tgt_rdata_one), .tgt_rdata_two(tgt_rdata_two),
      .tgt_rvalid_one(tgt_rvalid_one), .tgt_rvalid_two(tgt_rvalid_two),
      .tgt_wren(tgt_wren), .tgt_wvalid(tgt_wvalid), .dbg_state(dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish before 100us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [W:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected response %h expected none", name, act);
   endtask

   // Scoreboard monitor: pop and compare on every response strobe
   always @(negedge clk) begin
      if (read_valid_one) begin
         if (exp_q1.size() == 0) unexpected("r1_rsp", {read_err_one, read_data_one});
         else check("r1_rsp", {read_err_one, read_data_one}, exp_q1.pop_front());
      end
      if (read_valid_two) begin
         if (exp_q2.size() == 0) unexpected("r2_rsp", {read_err_two, read_data_two});
         else check("r2_rsp", {read_err_two, read_data_two}, exp_q2.pop_front());
      end
      if (write_valid) begin
         if (exp_qw.size() == 0) unexpected("w_rsp", {write_err, 32'h0});
         else check("w_rsp", {write_err, 32'h0}, exp_qw.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stimulus
   initial begin
      rst_n = 1'b0;
      read_one = 0; read_sign_one = 0; read_addr_one = '0; read_size_one = 2'd0;
      read_two = 0; read_sign_two = 0; read_addr_two = '0; read_size_two = 2'd0;
      wren = 0; write_size = 2'd0; write_addr = '0; write_data = 32'h5A5A_0000;
      tgt_rdata_one = '0; tgt_rdata_two = '0;
      tgt_rvalid_one = '0; tgt_rvalid_two = '0; tgt_wvalid = '0;

      // Reset with a live request: nothing may leak out
      read_one = 1; read_addr_one = 32'h0000_0104; read_size_one = 2'd2;
      step(); step();
      @(negedge clk);
      check("rst_valids", {read_valid_one, read_valid_two, write_valid}, 0);
      check("rst_errs", {read_err_one, read_err_two, write_err}, 0);
      check("rst_enables", {tgt_read_one, tgt_read_two, tgt_wren}, 0);
      check("rst_data", read_data_one | read_data_two, 0);
      check("rst_state", dbg_state, 0);

      // Release: held request is presented at once and taken on the next edge
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_enable", tgt_read_one, 2'b01);
      step();
      check("busy_state", dbg_state.r1, BUSY);
      tgt_rvalid_one = 2'b10; tgt_rdata_one[63:32] = 32'h1234_5678;
      @(negedge clk);
      check("busy_enable", tgt_read_one, 2'b01);
      step();
      tgt_rvalid_one = 2'b01; tgt_rdata_one[31:0] = 32'hDEAD_BEEF;
      exp_q1.push_back({1'b0, 32'hDEAD_BEEF});
      @(negedge clk);
      check("hit_enable", tgt_read_one, 2'b01);
      step();
      read_one = 0; tgt_rvalid_one = '0;

      // Unmapped read
      step();
      read_one = 1; read_addr_one = 32'h0000_2000; read_size_one = 2'd2;
      exp_q1.push_back({1'b1, 32'h0});
      @(negedge clk);
      check("unmapped_enable", tgt_read_one, 2'b00);
      step(); step();
      read_one = 0;

      // Misaligned word read and halfword write in the same cycle
      read_two = 1; read_addr_two = 32'h0000_1002; read_size_two = 2'd2;
      wren = 1; write_addr = 32'h0000_1001; write_size = 2'd1;
      exp_q2.push_back({1'b1, 32'h0});
      exp_qw.push_back({1'b1, 32'h0});
      @(negedge clk);
      check("misalign_enables", {tgt_read_two, tgt_wren}, 0);
      step(); step();
      read_two = 0; wren = 0;

      // Byte read answered in the request cycle; illegal-size write
      read_two = 1; read_addr_two = 32'h0000_1003; read_size_two = 2'd0;
      tgt_rvalid_two = 2'b10; tgt_rdata_two[63:32] = 32'h0000_00A5;
      wren = 1; write_addr = 32'h0000_1000; write_size = 2'd3;
      exp_q2.push_back({1'b0, 32'h0000_00A5});
      exp_qw.push_back({1'b1, 32'h0});
      @(negedge clk);
      check("byte_enable", tgt_read_two, 2'b10);
      check("badsize_enable", tgt_wren, 2'b00);
      step();
      read_two = 0; tgt_rvalid_two = '0;
      step();
      wren = 0;

      // Timeout: target never answers
      begin
         int en_cycles = 0;
         bit seen = 0;
         read_one = 1; read_addr_one = 32'h0000_1000; read_size_one = 2'd2;
         exp_q1.push_back({1'b1, 32'h0});
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (tgt_read_one == 2'b10) en_cycles++;
            if (read_valid_one) begin
               seen = 1;
               check("timeout_enable_drop", tgt_read_one, 2'b00);
            end
            step();
         end
         read_one = 0;
         check("timeout_seen", seen, 1);
         check("timeout_en_cycles", en_cycles, 15);
         @(negedge clk);
         check("timeout_idle", dbg_state.r1, IDLE);
      end

      // Concurrency: three channels, staggered target responses
      step();
      read_one = 1; read_addr_one = 32'h0000_0010; read_size_one = 2'd2;
      read_two = 1; read_addr_two = 32'h0000_1020; read_size_two = 2'd2;
      wren = 1; write_addr = 32'h0000_1040; write_size = 2'd2;
      @(negedge clk);
      check("conc_enables", {tgt_read_one, tgt_read_two, tgt_wren}, 6'b01_10_10);
      step();
      tgt_wvalid = 2'b10; exp_qw.push_back({1'b0, 32'h0});
      tgt_rvalid_one = 2'b10; tgt_rdata_one[63:32] = 32'hBAD0_BAD0;
      read_addr_one = 32'h0000_1010;
      @(negedge clk);
      check("conc_r1_latched", tgt_read_one, 2'b01);
      step();
      wren = 0; tgt_wvalid = '0; tgt_rvalid_one = '0;
      tgt_rvalid_two = 2'b10; tgt_rdata_two[63:32] = 32'h1111_2222;
      exp_q2.push_back({1'b0, 32'h1111_2222});
      step();
      read_two = 0; tgt_rvalid_two = '0;
      tgt_rvalid_one = 2'b01; tgt_rdata_one[31:0] = 32'hAAAA_5555;
      exp_q1.push_back({1'b0, 32'hAAAA_5555});
      step();
      read_one = 0; tgt_rvalid_one = '0;

      // Reset while two channels are BUSY
      step();
      read_one = 1; read_addr_one = 32'h0000_0000; read_size_one = 2'd2;
      read_two = 1; read_addr_two = 32'h0000_1000; read_size_two = 2'd0;
      step();
      check("pre_rst_state", {dbg_state.r2, dbg_state.r1}, {BUSY, BUSY});
      #2;
      rst_n = 1'b0;
      tgt_rvalid_one = 2'b01; tgt_rvalid_two = 2'b10;
      #1;
      check("rst_async_enables", {tgt_read_one, tgt_read_two}, 0);
      @(negedge clk);
      check("rst_mid_valids", {read_valid_one, read_valid_two}, 0);
      step();
      read_one = 0; read_two = 0; tgt_rvalid_one = '0; tgt_rvalid_two = '0;
      step();
      rst_n = 1'b1;
      step(); step();
      @(negedge clk);
      check("queues_drained", exp_q1.size() + exp_q2.size() + exp_qw.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
